// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/funct constants, control encodings and the decoded bundle type.
// Optional branch decode (blez/bgtz/regimm) is enabled by defining BRANCH_EXT_EN.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

`ifdef BRANCH_EXT_EN
  localparam bit BRANCH_EXT = 1'b1;
`else
  localparam bit BRANCH_EXT = 1'b0;
`endif

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JUMP = 2'b01,
    PC_REG  = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    M2R_ALU  = 2'b00,
    M2R_MEM  = 2'b01,
    M2R_LINK = 2'b11
  } memtoreg_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_BEQ   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_ORI   = 3'b011,
    ALU_ANDI  = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_XORI  = 3'b110
  } aluop_e;

  typedef enum logic [2:0] {
    BR_BEQ    = 3'b000,
    BR_BNE    = 3'b001,
    BR_BLEZ   = 3'b010,
    BR_BGTZ   = 3'b011,
    BR_REGIMM = 3'b100
  } br_type_e;

  typedef struct packed {
    pcsrc_e     pcsrc;
    logic       branch;
    br_type_e   branch_type;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    memtoreg_e  memtoreg;
    logic       alusrc1;
    logic       alusrc2;
    logic       extop;
    logic       luop;
    logic [3:0] aluop;
    logic [4:0] wdst;
    logic [4:0] rs;
    logic [4:0] rt;
  } ctrl_t;

  // A bubble writes nothing and carries no register fields.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction-to-control-bundle decoder.
// Defining BRANCH_EXT_EN adds blez/bgtz/regimm decode; otherwise those opcodes are NOPs.
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int RA_REG = 31
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        reads_rt
);

  localparam logic [4:0] RA = 5'(RA_REG);

  logic [5:0] op;
  logic [5:0] funct;
  aluop_e     alu_lo;
  logic       known;
  logic       unused_shamt;

  assign op           = inst[31:26];
  assign funct        = inst[5:0];
  assign unused_shamt = ^inst[10:6];

  always_comb begin
    ctrl      = CTRL_BUBBLE;
    ctrl.rs   = inst[25:21];
    ctrl.rt   = inst[20:16];
    ctrl.wdst = inst[20:16];
    alu_lo    = ALU_ADD;
    known     = 1'b1;
    reads_rt  = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.wdst     = inst[15:11];
        ctrl.regwrite = 1'b1;
        alu_lo        = ALU_RTYPE;
        reads_rt      = 1'b1;
        case (funct)
          FN_JR: begin
            ctrl.pcsrc    = PC_REG;
            ctrl.regwrite = 1'b0;
          end
          FN_JALR: begin
            ctrl.pcsrc    = PC_REG;
            ctrl.memtoreg = M2R_LINK;
            ctrl.wdst     = RA;
          end
          FN_SLL, FN_SRL, FN_SRA: ctrl.alusrc1 = 1'b1;
          default: ;
        endcase
      end
      OP_J: ctrl.pcsrc = PC_JUMP;
      OP_JAL: begin
        ctrl.pcsrc    = PC_JUMP;
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = M2R_LINK;
        ctrl.wdst     = RA;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.branch_type = BR_BEQ;
        ctrl.extop       = 1'b1;
        alu_lo           = ALU_BEQ;
        reads_rt         = 1'b1;
      end
      OP_BNE: begin
        ctrl.branch      = 1'b1;
        ctrl.branch_type = BR_BNE;
        ctrl.extop       = 1'b1;
        reads_rt         = 1'b1;
      end
      OP_REGIMM, OP_BLEZ, OP_BGTZ: begin
        if (BRANCH_EXT) begin
          ctrl.branch = 1'b1;
          ctrl.extop  = 1'b1;
          if (op == OP_BLEZ)      ctrl.branch_type = BR_BLEZ;
          else if (op == OP_BGTZ) ctrl.branch_type = BR_BGTZ;
          else                    ctrl.branch_type = BR_REGIMM;
        end else begin
          known = 1'b0;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc2  = 1'b1;
        ctrl.extop    = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI);
        ctrl.luop     = (op == OP_LUI);
        case (op)
          OP_SLTI, OP_SLTIU: alu_lo = ALU_SLT;
          OP_ANDI:           alu_lo = ALU_ANDI;
          OP_ORI:            alu_lo = ALU_ORI;
          OP_XORI:           alu_lo = ALU_XORI;
          default:           alu_lo = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = M2R_MEM;
        ctrl.alusrc2  = 1'b1;
        ctrl.extop    = 1'b1;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc2  = 1'b1;
        ctrl.extop    = 1'b1;
        reads_rt      = 1'b1;
      end
      default: known = 1'b0;
    endcase
    // Unknown opcodes become a NOP that still counts as a valid instruction.
    if (!known) ctrl.wdst = '0;
    ctrl.aluop = known ? {op[0], alu_lo} : 4'b0000;
  end

endmodule

// File: rtl/pipe_ctrl_decoder.sv
// ID-stage control decoder: one-entry output register with valid/ready handshake,
// load-use stall insertion, flush squash and a saturating stall counter.
module pipe_ctrl_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int RA_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  output logic             id_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [1:0]       ex_pcsrc,
  output logic             ex_branch,
  output logic [2:0]       ex_branch_type,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic [1:0]       ex_memtoreg,
  output logic             ex_alusrc1,
  output logic             ex_alusrc2,
  output logic             ex_extop,
  output logic             ex_luop,
  output logic [3:0]       ex_aluop,
  output logic [4:0]       ex_wdst,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: an instruction transfers on a rising edge where if_valid && id_ready;
  // the held bundle transfers to EX on an edge where ex_valid && ex_ready.
  typedef enum logic {EMPTY, FULL} state_e;

  state_e state, state_next;
  ctrl_t  bundle, bundle_next;
  ctrl_t  dec;
  logic   dec_reads_rt;
  logic   hazard;
  logic   load_en;
  logic   stall_inc;

  ctrl_decode #(.RA_REG(RA_REG)) u_decode (
    .inst     (if_inst),
    .ctrl     (dec),
    .reads_rt (dec_reads_rt)
  );

  assign ex_valid = (state == FULL);
  assign load_en  = ex_ready || !ex_valid;

  always_comb begin
    hazard = ex_valid && bundle.memread && (bundle.wdst != 5'd0) &&
             ((bundle.wdst == if_inst[25:21]) ||
              (dec_reads_rt && (bundle.wdst == if_inst[20:16])));
  end

  always_comb begin
    state_next  = state;
    bundle_next = bundle;
    id_ready    = 1'b0;
    stall_inc   = 1'b0;
    if (flush) begin
      state_next  = EMPTY;
      bundle_next = CTRL_BUBBLE;
      id_ready    = 1'b1;
    end else if (load_en) begin
      id_ready = !hazard;
      if (if_valid && !hazard) begin
        state_next  = FULL;
        bundle_next = dec;
      end else begin
        state_next  = EMPTY;
        bundle_next = CTRL_BUBBLE;
        // Only a bubble that displaces a real waiting instruction is a load-use stall.
        stall_inc   = if_valid && hazard;
      end
    end
    if (reset) id_ready = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      bundle <= CTRL_BUBBLE;
    end else begin
      state  <= state_next;
      bundle <= bundle_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_pcsrc       = bundle.pcsrc;
  assign ex_branch      = bundle.branch;
  assign ex_branch_type = bundle.branch_type;
  assign ex_regwrite    = bundle.regwrite;
  assign ex_memread     = bundle.memread;
  assign ex_memwrite    = bundle.memwrite;
  assign ex_memtoreg    = bundle.memtoreg;
  assign ex_alusrc1     = bundle.alusrc1;
  assign ex_alusrc2     = bundle.alusrc2;
  assign ex_extop       = bundle.extop;
  assign ex_luop        = bundle.luop;
  assign ex_aluop       = bundle.aluop;
  assign ex_wdst        = bundle.wdst;
  assign ex_rs          = bundle.rs;
  assign ex_rt          = bundle.rt;

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Bench for pipe_ctrl_decoder: decode table plus hazard, hold, flush, saturation and reset sequences.
module tb_pipe_ctrl_decoder;

  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic          id_ready;
  logic          flush;
  logic          ex_ready;
  logic          ex_valid;
  logic [1:0]    ex_pcsrc;
  logic          ex_branch;
  logic [2:0]    ex_branch_type;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic [1:0]    ex_memtoreg;
  logic          ex_alusrc1;
  logic          ex_alusrc2;
  logic          ex_extop;
  logic          ex_luop;
  logic [3:0]    ex_aluop;
  logic [4:0]    ex_wdst;
  logic [4:0]    ex_rs;
  logic [4:0]    ex_rt;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl_decoder #(.CNT_W(CW), .RA_REG(31)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pcsrc(ex_pcsrc), .ex_branch(ex_branch), .ex_branch_type(ex_branch_type),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2),
    .ex_extop(ex_extop), .ex_luop(ex_luop), .ex_aluop(ex_aluop), .ex_wdst(ex_wdst),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] inst;
    logic [18:0] ctl;
    logic [4:0]  wdst;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  logic [33:0] act_vec;
  assign act_vec = {ex_pcsrc, ex_branch, ex_branch_type, ex_regwrite, ex_memread,
                    ex_memwrite, ex_memtoreg, ex_alusrc1, ex_alusrc2, ex_extop,
                    ex_luop, ex_aluop, ex_wdst, ex_rs, ex_rt};

  int          tests = 0;
  int          fails = 0;
  int          exp_stall;
  logic [33:0] exp_q[$];
  logic [33:0] held;

  function automatic logic [18:0] mk(input logic [1:0] pc, input logic br, input logic [2:0] bt,
                                     input logic rw, input logic mr, input logic mw,
                                     input logic [1:0] m2r, input logic a1, input logic a2,
                                     input logic ext, input logic lu, input logic [3:0] alu);
    return {pc, br, bt, rw, mr, mw, m2r, a1, a2, ext, lu, alu};
  endfunction

  function automatic logic [33:0] ev(input logic [31:0] inst, input logic [18:0] ctl,
                                     input logic [4:0] wd);
    return {ctl, wd, inst[25:21], inst[20:16]};
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_stall(input string name);
    check(name, 34'(stall_cnt), 34'(exp_stall));
  endtask

  // driver: one cycle of stimulus, push on acceptance, check after the edge
  task automatic step(input logic v, input logic [31:0] inst, input logic rdy, input logic fl,
                      input logic exp_rdy, input logic [33:0] exp, input string name);
    logic acc;
    if_valid = v;
    if_inst  = inst;
    ex_ready = rdy;
    flush    = fl;
    #1;
    check({name, "/id_ready"}, 34'(id_ready), 34'(exp_rdy));
    acc = v && id_ready && !fl;
    if (acc) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (acc) begin
      if (!ex_valid) begin
        check({name, "/latency"}, 34'(ex_valid), 34'd1);
        void'(exp_q.pop_front());
      end else begin
        held = exp_q.pop_front();
        check({name, "/bundle"}, act_vec, held);
      end
    end else if (ex_valid) begin
      check({name, "/hold"}, act_vec, held);
    end else begin
      check({name, "/bubble"}, {act_vec[33:15], 15'd0}, 34'd0);
    end
    if_valid = 1'b0;
    if_inst  = '0;
    flush    = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [31:0] I_ADDI = 32'h20080005;
  localparam logic [31:0] I_ADD  = 32'h010B5020;
  localparam logic [31:0] I_LW8  = 32'h8D280000;
  localparam logic [31:0] I_SW8  = 32'hAC680000;
  localparam logic [31:0] I_ADR8 = 32'h21280001;
  localparam logic [31:0] I_LW0  = 32'h8D200000;
  localparam logic [31:0] I_ADD0 = 32'h000B5020;
  localparam logic [31:0] I_ORI  = 32'h34A40001;

  logic [18:0] c_addi, c_add, c_lw, c_sw;

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_inst = '0; ex_ready = 1'b0; flush = 1'b0;
    exp_stall = 0;
    held = '0;
    c_addi = mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 0, 1, 1, 0, 4'b0000);
    c_add  = mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0010);
    c_lw   = mk(2'b00, 0, 3'b000, 1, 1, 0, 2'b01, 0, 1, 1, 0, 4'b1000);
    c_sw   = mk(2'b00, 0, 3'b000, 0, 0, 1, 2'b00, 0, 1, 1, 0, 4'b1000);

    vecs[0]  = '{32'h0C000010, mk(2'b01, 0, 3'b000, 1, 0, 0, 2'b11, 0, 0, 0, 0, 4'b1000), 5'd31};
    vecs[1]  = '{I_ADD,        c_add, 5'd10};
    vecs[2]  = '{32'h00031100, mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 1, 0, 0, 0, 4'b0010), 5'd2};
    vecs[3]  = '{32'h00031042, mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 1, 0, 0, 0, 4'b0010), 5'd2};
    vecs[4]  = '{32'h00031043, mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 1, 0, 0, 0, 4'b0010), 5'd2};
    vecs[5]  = '{32'h03E00008, mk(2'b11, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0010), 5'd0};
    vecs[6]  = '{32'h00A0F809, mk(2'b11, 0, 3'b000, 1, 0, 0, 2'b11, 0, 0, 0, 0, 4'b0010), 5'd31};
    vecs[7]  = '{32'h10220003, mk(2'b00, 1, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'b0001), 5'd2};
    vecs[8]  = '{32'h14220003, mk(2'b00, 1, 3'b001, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'b1000), 5'd2};
    vecs[9]  = '{32'h30A400FF, mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 0, 1, 0, 0, 4'b0100), 5'd4};
    vecs[10] = '{I_ORI,        mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 0, 1, 0, 0, 4'b1011), 5'd4};
    vecs[11] = '{32'h38A40001, mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 0, 1, 0, 0, 4'b0110), 5'd4};
    vecs[12] = '{32'h28A40001, mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 0, 1, 1, 0, 4'b0101), 5'd4};
    vecs[13] = '{32'h2CA40001, mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 0, 1, 0, 0, 4'b1101), 5'd4};
    vecs[14] = '{32'h3C041234, mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 0, 1, 0, 1, 4'b1000), 5'd4};
    vecs[15] = '{I_LW8,        c_lw, 5'd8};
    vecs[16] = '{32'hAC620004, c_sw, 5'd2};
    vecs[17] = '{32'h24C7FFFF, mk(2'b00, 0, 3'b000, 1, 0, 0, 2'b00, 0, 1, 1, 0, 4'b1000), 5'd7};
    vecs[18] = '{32'h08000010, mk(2'b01, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000), 5'd0};
    vecs[19] = '{32'hFC221234, 19'd0, 5'd0};
    vecs[20] = '{I_ADDI,       c_addi, 5'd8};
`ifdef BRANCH_EXT_EN
    vecs[21] = '{32'h19000003, mk(2'b00, 1, 3'b010, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'b0000), 5'd0};
    vecs[22] = '{32'h1D000003, mk(2'b00, 1, 3'b011, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'b1000), 5'd0};
    vecs[23] = '{32'h05010003, mk(2'b00, 1, 3'b100, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'b1000), 5'd1};
`else
    vecs[21] = '{32'h19000003, 19'd0, 5'd0};
    vecs[22] = '{32'h1D000003, 19'd0, 5'd0};
    vecs[23] = '{32'h05010003, 19'd0, 5'd0};
`endif

    // reset state, with a valid instruction offered
    repeat (3) @(negedge clk);
    if_valid = 1'b1;
    if_inst  = I_ADDI;
    ex_ready = 1'b1;
    #1;
    check("rst/id_ready", 34'(id_ready), 34'd0);
    check("rst/ex_valid", 34'(ex_valid), 34'd0);
    check("rst/outputs", act_vec, 34'd0);
    check_stall("rst/stall_cnt");
    if_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    step(1'b1, I_ADDI, 1'b1, 1'b0, 1'b1, ev(I_ADDI, c_addi, 5'd8), "first_addi");

    for (int i = 0; i < NV; i++)
      step(1'b1, vecs[i].inst, 1'b1, 1'b0, 1'b1, ev(vecs[i].inst, vecs[i].ctl, vecs[i].wdst),
           $sformatf("vec%0d", i));
    check_stall("table/stall_cnt");

    // load-use on rs
    step(1'b1, I_LW8, 1'b1, 1'b0, 1'b1, ev(I_LW8, c_lw, 5'd8), "lu_lw");
    step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 34'd0, "lu_stall");
    exp_stall = 1;
    check_stall("lu/stall_cnt");
    step(1'b1, I_ADD, 1'b1, 1'b0, 1'b1, ev(I_ADD, c_add, 5'd10), "lu_add");

    // load-use on rt through sw
    step(1'b1, I_LW8, 1'b1, 1'b0, 1'b1, ev(I_LW8, c_lw, 5'd8), "rt_lw");
    step(1'b1, I_SW8, 1'b1, 1'b0, 1'b0, 34'd0, "rt_stall");
    exp_stall = 2;
    check_stall("rt/stall_cnt");
    step(1'b1, I_SW8, 1'b1, 1'b0, 1'b1, ev(I_SW8, c_sw, 5'd8), "rt_sw");

    // rt match on an instruction that does not read rt, and a load to $0
    step(1'b1, I_LW8, 1'b1, 1'b0, 1'b1, ev(I_LW8, c_lw, 5'd8), "nh_lw");
    step(1'b1, I_ADR8, 1'b1, 1'b0, 1'b1, ev(I_ADR8, c_addi, 5'd8), "nh_addi");
    step(1'b1, I_LW0, 1'b1, 1'b0, 1'b1, ev(I_LW0, c_lw, 5'd0), "z_lw");
    step(1'b1, I_ADD0, 1'b1, 1'b0, 1'b1, ev(I_ADD0, c_add, 5'd10), "z_add");
    check_stall("nh/stall_cnt");

    // hazard while EX back-pressures: hold, no count, then stall once released
    step(1'b1, I_LW8, 1'b1, 1'b0, 1'b1, ev(I_LW8, c_lw, 5'd8), "bp_lw");
    step(1'b1, I_ADD, 1'b0, 1'b0, 1'b0, 34'd0, "bp_hold");
    check_stall("bp/stall_hold");
    step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 34'd0, "bp_stall");
    exp_stall = 3;
    check_stall("bp/stall_cnt");
    step(1'b1, I_ADD, 1'b1, 1'b0, 1'b1, ev(I_ADD, c_add, 5'd10), "bp_add");

    // hold three cycles, then flush
    step(1'b1, I_ADDI, 1'b1, 1'b0, 1'b1, ev(I_ADDI, c_addi, 5'd8), "h_addi");
    repeat (3) step(1'b1, I_ORI, 1'b0, 1'b0, 1'b0, 34'd0, "h_hold");
    step(1'b1, I_ORI, 1'b0, 1'b1, 1'b1, 34'd0, "h_flush");
    check_stall("h/stall_cnt");

    // flush overrides a hazard and is not counted
    step(1'b1, I_LW8, 1'b1, 1'b0, 1'b1, ev(I_LW8, c_lw, 5'd8), "fh_lw");
    step(1'b1, I_ADD, 1'b1, 1'b1, 1'b1, 34'd0, "fh_flush");
    check_stall("fh/stall_cnt");
    step(1'b1, I_ADD, 1'b1, 1'b0, 1'b1, ev(I_ADD, c_add, 5'd10), "fh_add");

    // counter saturation
    for (int i = 0; i < 6; i++) begin
      step(1'b1, I_LW8, 1'b1, 1'b0, 1'b1, ev(I_LW8, c_lw, 5'd8), "sat_lw");
      step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 34'd0, "sat_stall");
      if (exp_stall < (1 << CW) - 1) exp_stall++;
      check_stall($sformatf("sat%0d/stall_cnt", i));
    end

    // reset in the middle of a stall
    step(1'b1, I_LW8, 1'b1, 1'b0, 1'b1, ev(I_LW8, c_lw, 5'd8), "mr_lw");
    if_valid = 1'b1;
    if_inst  = I_ADD;
    ex_ready = 1'b0;
    #2;
    check("mr/pre_id_ready", 34'(id_ready), 34'd0);
    reset = 1'b1;
    #1;
    check("mr/ex_valid", 34'(ex_valid), 34'd0);
    check("mr/outputs", act_vec, 34'd0);
    check("mr/id_ready", 34'(id_ready), 34'd0);
    exp_stall = 0;
    check_stall("mr/stall_cnt");
    exp_q.delete();
    if_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, I_ADD, 1'b1, 1'b0, 1'b1, ev(I_ADD, c_add, 5'd10), "mr_add");
    check_stall("mr/stall_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
